conv_post_pad: RTL and testbench

- Stage directly downstream of the 3x3 stride-1 convolution engine. Consumes its raw 32-bit signed accumulator stream: (D-2)x(D-2) results per frame, row-major.
- Per result: applies activation, rounding right-shift and unsigned 8-bit saturation.
- Inserts a one-pixel border of pad_value, so the frame emitted is a full DxD 8-bit image, row-major, on a valid/ready stream.
- Output feeds the frame writer / next layer buffer.

---
 rtl/conv_post_pad.sv | 273 +++++++++++++++++++++++++++
 tb/tb_conv_post_pad.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_post_pad.sv
// conv_post_pad
// Post-processing stage behind the 3x3 stride-1 convolution engine.
// Each 32-bit signed accumulator result goes through activation, a
// rounding arithmetic right shift and unsigned saturation. A one-pixel
// border of pad_value is added around the (D-2)x(D-2) results, so each
// frame leaves as a full DxD image on a valid/ready stream.
//
// The output side is a single register stage. It holds out_pixel,
// out_valid and out_last. That register can load whenever it is empty
// or is being drained in the same cycle. Border positions load the pad
// value without consuming input. Body positions load only when an
// input result is offered. So in_ready is the only combinational
// output: it must answer in the same cycle that the result is offered.

module conv_post_pad #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8,
    parameter int DIM_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIM_WIDTH-1:0] img_dim,
    input  logic [1:0]           act_mode,
    input  logic [4:0]           shift,
    input  logic [OUT_WIDTH-1:0] pad_value,
    input  logic [ACC_WIDTH-1:0] in_result,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    // Two extra bits cover two cases. The first is |most negative|
    // under mode 2. The second is the rounding bias added on top of it.
    localparam int CALC_W = ACC_WIDTH + 2;

    localparam logic signed [CALC_W-1:0]   CALC_ZERO = {CALC_W{1'b0}};
    localparam logic signed [CALC_W-1:0]   CALC_ONE  = {{(CALC_W-1){1'b0}}, 1'b1};
    localparam logic signed [CALC_W-1:0]   SAT_MAX   = {{(CALC_W-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
    localparam logic [OUT_WIDTH-1:0]       PIX_ZERO  = {OUT_WIDTH{1'b0}};
    localparam logic [OUT_WIDTH-1:0]       PIX_MAX   = {OUT_WIDTH{1'b1}};
    localparam logic [DIM_WIDTH-1:0]       DIM_ZERO  = {DIM_WIDTH{1'b0}};
    localparam logic [DIM_WIDTH-1:0]       DIM_ONE   = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIM_WIDTH-1:0]       DIM_THREE = {{(DIM_WIDTH-2){1'b0}}, 2'b11};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Activation, rounding shift and saturation of one conv result.
    function automatic logic [OUT_WIDTH-1:0] post_process(
        input logic [ACC_WIDTH-1:0] x,
        input logic [1:0]           mode,
        input logic [4:0]           sh
    );
        logic signed [CALC_W-1:0] xs;
        logic signed [CALC_W-1:0] a;
        logic signed [CALC_W-1:0] bias;
        logic signed [CALC_W-1:0] r;
        logic [OUT_WIDTH-1:0]     res;
        xs   = {{2{x[ACC_WIDTH-1]}}, x};
        a    = xs;
        bias = CALC_ZERO;
        r    = CALC_ZERO;
        res  = PIX_ZERO;
        case (mode)
            2'd1:    a = xs[CALC_W-1] ? CALC_ZERO : xs;
            2'd2:    a = xs[CALC_W-1] ? -xs : xs;
            default: a = xs;
        endcase
        if (sh != 5'd0) begin
            bias = CALC_ONE <<< (sh - 5'd1);
            r    = (a + bias) >>> sh;
        end else begin
            r = a;
        end
        if (r[CALC_W-1]) begin
            res = PIX_ZERO;
        end else if (r > SAT_MAX) begin
            res = PIX_MAX;
        end else begin
            res = r[OUT_WIDTH-1:0];
        end
        return res;
    endfunction

    state_t                 state_q, state_d;
    logic [DIM_WIDTH-1:0]   row_q, row_d;
    logic [DIM_WIDTH-1:0]   col_q, col_d;
    logic [DIM_WIDTH-1:0]   dim_q, dim_d;
    logic [1:0]             mode_q, mode_d;
    logic [4:0]             shift_q, shift_d;
    logic [OUT_WIDTH-1:0]   pad_q, pad_d;
    logic [OUT_WIDTH-1:0]   out_pixel_q, out_pixel_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   start_ok_s;
    logic [DIM_WIDTH-1:0]   dim_m1_s;
    logic                   border_s;
    logic                   at_last_s;
    logic                   may_load_s;
    logic                   xfer_s;
    logic                   load_s;
    logic                   load_pad_s;
    logic                   in_ready_s;

    // Position decode and handshake qualifiers shared by FSM and datapath.
    always_comb begin
        start_ok_s = (state_q == S_IDLE) && start && (img_dim >= DIM_THREE);
        dim_m1_s   = dim_q - DIM_ONE;
        border_s   = (row_q == DIM_ZERO) || (row_q == dim_m1_s) ||
                     (col_q == DIM_ZERO) || (col_q == dim_m1_s);
        at_last_s  = (row_q == dim_m1_s) && (col_q == dim_m1_s);
        may_load_s = !out_valid_q || out_ready;
        xfer_s     = out_valid_q && out_ready;
    end

    // FSM state register; reset aborts any frame in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE -> RUN on start, RUN -> DRAIN on last load, DRAIN -> IDLE on its transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (load_s && at_last_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (xfer_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: decide whether the output register loads and from where.
    always_comb begin
        in_ready_s = 1'b0;
        load_s     = 1'b0;
        load_pad_s = 1'b0;
        case (state_q)
            S_RUN: begin
                if (border_s) begin
                    load_s     = may_load_s;
                    load_pad_s = 1'b1;
                end else begin
                    in_ready_s = may_load_s;
                    load_s     = may_load_s && in_valid;
                end
            end
            default: begin
                in_ready_s = 1'b0;
                load_s     = 1'b0;
                load_pad_s = 1'b0;
            end
        endcase
    end

    // Datapath next state: config latch, raster counters, output register, status.
    always_comb begin
        dim_d       = dim_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        pad_d       = pad_q;
        row_d       = row_q;
        col_d       = col_q;
        out_pixel_d = out_pixel_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (start_ok_s) begin
            dim_d   = img_dim;
            mode_d  = act_mode;
            shift_d = shift;
            pad_d   = pad_value;
            row_d   = DIM_ZERO;
            col_d   = DIM_ZERO;
        end else if (load_s) begin
            if (col_q == dim_m1_s) begin
                col_d = DIM_ZERO;
                row_d = row_q + DIM_ONE;
            end else begin
                col_d = col_q + DIM_ONE;
                row_d = row_q;
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end

        if (load_s) begin
            out_pixel_d = load_pad_s ? pad_q : post_process(in_result, mode_q, shift_q);
            out_valid_d = 1'b1;
            out_last_d  = at_last_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DRAIN) && xfer_s;
    end

    // Datapath registers; async reset clears every output and counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dim_q       <= DIM_ZERO;
            mode_q      <= 2'd0;
            shift_q     <= 5'd0;
            pad_q       <= PIX_ZERO;
            row_q       <= DIM_ZERO;
            col_q       <= DIM_ZERO;
            out_pixel_q <= PIX_ZERO;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            dim_q       <= dim_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            pad_q       <= pad_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_pixel_q <= out_pixel_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_pixel = out_pixel_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_post_pad.sv
// Self-checking bench for conv_post_pad: arithmetic table on 3x3 frames,
// reference-model comparison of random and directed frames, backpressure,
// mid-frame reset, ignored starts and a full 224x224 frame.

module tb_conv_post_pad;

    logic               clock;
    logic               reset;
    logic               start;
    logic [7:0]         img_dim;
    logic [1:0]         act_mode;
    logic [4:0]         shift;
    logic [7:0]         pad_value;
    logic signed [31:0] in_result;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         out_pixel;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic               done;

    conv_post_pad #(.ACC_WIDTH(32), .OUT_WIDTH(8), .DIM_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .start(start), .img_dim(img_dim),
        .act_mode(act_mode), .shift(shift), .pad_value(pad_value),
        .in_result(in_result), .in_valid(in_valid), .in_ready(in_ready),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic signed [31:0] in_vals [0:65535];
    logic [7:0]         got_px  [0:65535];
    logic               got_last[0:65535];
    int ntx, nacc;
    bit done_seen;

    typedef struct {
        logic signed [31:0] x;
        logic [1:0]         mode;
        logic [4:0]         sh;
        logic [7:0]         pad;
        logic [7:0]         exp;
    } vec_t;
    vec_t tbl [16];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the rules, on 64-bit integers.
    function automatic logic [7:0] ref_post(input logic signed [31:0] x, input int mode, input int sh);
        longint a, r;
        a = x;
        if (mode == 1 && a < 0) a = 0;
        else if (mode == 2 && a < 0) a = -a;
        if (sh > 0) r = (a + (longint'(1) << (sh - 1))) >>> sh;
        else r = a;
        if (r < 0) return 8'd0;
        if (r > 255) return 8'd255;
        return r[7:0];
    endfunction

    function automatic bit is_body(input int p, input int d);
        int r, c;
        if (p >= d * d) return 1'b0;
        r = p / d;
        c = p % d;
        return (r > 0 && r < d - 1 && c > 0 && c < d - 1);
    endfunction

    function automatic logic [7:0] ref_pixel(input int i, input int d, input int mode, input int sh, input logic [7:0] pad);
        int r, c;
        r = i / d;
        c = i % d;
        if (!is_body(i, d)) return pad;
        return ref_post(in_vals[(r - 1) * (d - 2) + (c - 1)], mode, sh);
    endfunction

    // Run one frame. rdy_mode: 0 always ready, 1 toggling, 2 random.
    task automatic run_frame(input int d, input logic [1:0] mode, input logic [4:0] sh,
                             input logic [7:0] pad, input int rdy_mode, input bit gaps,
                             input bit extra, input int mid_start, input int abort_at);
        int lim, p, n_in;
        bit stalled, pend_done;
        logic [7:0] prev_px;
        logic prev_last;
        n_in = (d - 2) * (d - 2);
        ntx = 0; nacc = 0; done_seen = 1'b0;
        stalled = 1'b0; pend_done = 1'b0; prev_px = 8'd0; prev_last = 1'b0;
        lim = 4 * d * d + 50;
        @(negedge clock);
        start = 1'b1; img_dim = d[7:0]; act_mode = mode; shift = sh; pad_value = pad;
        for (int cyc = 0; cyc < lim && !done_seen; cyc++) begin
            @(negedge clock);
            start = (mid_start > 0 && cyc == mid_start);
            img_dim = 8'd5; act_mode = 2'($urandom); shift = 5'($urandom); pad_value = 8'($urandom);
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (nacc < n_in) begin
                in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_result = in_vals[nacc];
            end else begin
                in_valid  = extra;
                in_result = $urandom;
            end
            #1;
            if (cyc == 0) check("busy_after_start", busy, 1);
            if (abort_at >= 0 && ntx == abort_at) begin
                in_valid = 1'b0;
                reset = 1'b0;
                #1;
                check("abort_out_valid", out_valid, 0);
                check("abort_out_pixel", out_pixel, 0);
                check("abort_out_last", out_last, 0);
                check("abort_busy", busy, 0);
                check("abort_in_ready", in_ready, 0);
                @(negedge clock);
                reset = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    #1;
                    check("abort_no_done", done, 0);
                    check("abort_idle", busy, 0);
                end
                return;
            end
            check("done_timing", done, pend_done);
            if (pend_done) begin
                check("busy_after_done", busy, 0);
                done_seen = 1'b1;
            end
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_pixel", out_pixel, prev_px);
                check("stall_last", out_last, prev_last);
            end
            p = ntx + int'(out_valid);
            if (in_ready) check("in_ready_body_only", is_body(p, d), 1);
            if (in_valid && in_ready) nacc++;
            pend_done = 1'b0;
            if (out_valid && out_ready) begin
                got_px[ntx]   = out_pixel;
                got_last[ntx] = out_last;
                ntx++;
                pend_done = (ntx == d * d);
            end
            stalled   = out_valid && !out_ready;
            prev_px   = out_pixel;
            prev_last = out_last;
        end
        check("frame_done_seen", done_seen, 1);
        check("pixels_emitted", ntx, d * d);
        check("inputs_accepted", nacc, (d - 2) * (d - 2));
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("done_one_cycle", done, 0);
    endtask

    task automatic compare_frame(input int d, input int mode, input int sh, input logic [7:0] pad);
        for (int i = 0; i < d * d; i++) begin
            check("pixel", got_px[i], ref_pixel(i, d, mode, sh, pad));
            check("out_last", got_last[i], (i == d * d - 1));
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; img_dim = 8'd0; act_mode = 2'd0; shift = 5'd0;
        pad_value = 8'd0; in_result = 32'sd0; in_valid = 1'b0; out_ready = 1'b0;

        tbl[0]  = '{x: -32'sd300,          mode: 2'd2, sh: 5'd0,  pad: 8'hFF, exp: 8'd255};
        tbl[1]  = '{x: -32'sd300,          mode: 2'd1, sh: 5'd0,  pad: 8'hFF, exp: 8'd0};
        tbl[2]  = '{x: 32'sh180,           mode: 2'd0, sh: 5'd8,  pad: 8'h00, exp: 8'd2};
        tbl[3]  = '{x: 32'sh17F,           mode: 2'd0, sh: 5'd8,  pad: 8'h00, exp: 8'd1};
        tbl[4]  = '{x: 32'sh7FFFFFFF,      mode: 2'd0, sh: 5'd0,  pad: 8'h00, exp: 8'd255};
        tbl[5]  = '{x: 32'sh80000000,      mode: 2'd2, sh: 5'd24, pad: 8'h11, exp: 8'd128};
        tbl[6]  = '{x: 32'sh80000000,      mode: 2'd0, sh: 5'd31, pad: 8'h22, exp: 8'd0};
        tbl[7]  = '{x: -32'sd1,            mode: 2'd0, sh: 5'd1,  pad: 8'h33, exp: 8'd0};
        tbl[8]  = '{x: 32'sd200,           mode: 2'd3, sh: 5'd0,  pad: 8'h44, exp: 8'd200};
        tbl[9]  = '{x: 32'sh7FFFFFFF,      mode: 2'd1, sh: 5'd31, pad: 8'h55, exp: 8'd1};
        tbl[10] = '{x: -32'sd255,          mode: 2'd2, sh: 5'd0,  pad: 8'h66, exp: 8'd255};
        tbl[11] = '{x: 32'sd1023,          mode: 2'd0, sh: 5'd2,  pad: 8'h77, exp: 8'd255};
        tbl[12] = '{x: 32'sd1017,          mode: 2'd0, sh: 5'd2,  pad: 8'h88, exp: 8'd254};
        tbl[13] = '{x: -32'sd7,            mode: 2'd3, sh: 5'd0,  pad: 8'h99, exp: 8'd0};
        tbl[14] = '{x: 32'sd256,           mode: 2'd2, sh: 5'd0,  pad: 8'hAA, exp: 8'd255};
        tbl[15] = '{x: 32'sd96,            mode: 2'd1, sh: 5'd5,  pad: 8'hBB, exp: 8'd3};

        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_pixel", out_pixel, 0);
        check("reset_out_last", out_last, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_in_ready", in_ready, 0);
        @(negedge clock);
        reset = 1'b1;

        // Arithmetic table on 3x3 frames: centre is the result, ring is pad.
        for (int i = 0; i < 16; i++) begin
            in_vals[0] = tbl[i].x;
            run_frame(3, tbl[i].mode, tbl[i].sh, tbl[i].pad, 0, 1'b0, 1'b0, 0, -1);
            for (int k = 0; k < 9; k++)
                check((k == 4) ? "tbl_centre" : "tbl_border", got_px[k], (k == 4) ? tbl[i].exp : tbl[i].pad);
        end

        // D=5, ReLU, results 1..9.
        for (int i = 0; i < 9; i++) in_vals[i] = i + 1;
        run_frame(5, 2'd1, 5'd0, 8'd0, 0, 1'b0, 1'b1, 0, -1);
        compare_frame(5, 1, 0, 8'd0);
        check("d5_px6", got_px[6], 8'd1);
        check("d5_px12", got_px[12], 8'd5);
        check("d5_px18", got_px[18], 8'd9);
        check("d5_px24", got_px[24], 8'd0);

        // Backpressure: toggling ready with gapped valid.
        for (int i = 0; i < 16; i++) in_vals[i] = $urandom_range(0, 400) - 100;
        run_frame(6, 2'd0, 5'd0, 8'h5A, 1, 1'b1, 1'b1, 0, -1);
        compare_frame(6, 0, 0, 8'h5A);

        // Random frames with random ready/valid and configuration.
        for (int f = 0; f < 6; f++) begin
            int d, m, s;
            logic [7:0] pd;
            d = $urandom_range(3, 12); m = $urandom_range(0, 3); s = $urandom_range(0, 31);
            pd = 8'($urandom);
            for (int i = 0; i < (d - 2) * (d - 2); i++)
                in_vals[i] = $signed($urandom) >>> $urandom_range(0, 31);
            run_frame(d, 2'(m), 5'(s), pd, 2, 1'b1, 1'b1, 0, -1);
            compare_frame(d, m, s, pd);
        end

        // Reset mid-frame after 10 pixels, then a clean frame.
        for (int i = 0; i < 9; i++) in_vals[i] = 10 * i;
        run_frame(5, 2'd0, 5'd0, 8'd3, 0, 1'b0, 1'b0, 0, 10);
        run_frame(5, 2'd0, 5'd0, 8'd3, 0, 1'b0, 1'b0, 0, -1);
        compare_frame(5, 0, 0, 8'd3);

        // img_dim below 3 is ignored.
        @(negedge clock);
        start = 1'b1; img_dim = 8'd2;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("small_dim_busy", busy, 0);
            check("small_dim_valid", out_valid, 0);
            @(negedge clock);
        end

        // Full 224x224 frame, mode 2, with a start pulse during it.
        for (int i = 0; i < 222 * 222; i++) in_vals[i] = $signed($urandom) >>> $urandom_range(20, 31);
        run_frame(224, 2'd2, 5'd0, 8'h01, 0, 1'b0, 1'b1, 1000, -1);
        compare_frame(224, 2, 0, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
